// File: rtl/dsp_mac_sequencer.sv
// Multiply-accumulate sequencer for one DSP48A1 slice: streams (a, b) pairs and returns the 48-bit sum.
// Optional sticky carry-out flag on res_ovf_o when DSP_MAC_OVF_EN is defined (tied to 0 otherwise).
module dsp_mac_sequencer #(
   parameter int LEN_W      = 8,
   parameter int MUL_LAT    = 2,
   parameter int OPMODE_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [17:0]      in_a_i,
   input  logic [17:0]      in_b_i,
   output logic [17:0]      dsp_a_o,
   output logic [17:0]      dsp_b_o,
   output logic             dsp_cea_o,
   output logic             dsp_ceb_o,
   output logic             dsp_cem_o,
   output logic             dsp_ceopmode_o,
   output logic             dsp_cep_o,
   output logic [7:0]       dsp_opmode_o,
   input  logic [47:0]      dsp_p_i,
   input  logic             dsp_carryout_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [47:0]      res_data_o,
   output logic             res_ovf_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_DONE
   } state_e;

   // Beat tracking depth: one stage past the P register marks "P now valid".
   localparam int PD = MUL_LAT + 1;
   localparam int FD = MUL_LAT - OPMODE_LAT;

   localparam logic [7:0] OPM_FIRST = 8'h01;
   localparam logic [7:0] OPM_ACC   = 8'h09;
   localparam logic [7:0] OPM_IDLE  = 8'h00;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             first_pend_q, first_pend_d;
   logic [PD:1]      vld_q, vld_d;
   logic [PD:1]      last_q, last_d;
   logic [FD:1]      first_q, first_d;
   logic [47:0]      res_data_q, res_data_d;

   logic beat;
   logic done_pulse;

   assign beat       = (state_q == S_ACCUM) && in_valid_i;
   assign done_pulse = vld_q[PD] && last_q[PD];

   // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      first_pend_d = first_pend_q;
      res_data_d   = res_data_q;
      vld_d        = (vld_q << 1)   | PD'(beat);
      last_d       = (last_q << 1)  | PD'(beat && (cnt_q == LEN_W'(1)));
      first_d      = (first_q << 1) | FD'(beat && first_pend_q);

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               first_pend_d = 1'b1;
               res_data_d   = '0;
               if (len_i != '0) begin
                  cnt_d   = len_i;
                  state_d = S_ACCUM;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_ACCUM: begin
            if (beat) begin
               cnt_d        = cnt_q - LEN_W'(1);
               first_pend_d = 1'b0;
               if (cnt_q == LEN_W'(1)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (done_pulse) begin
               res_data_d = dsp_p_i;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments only; the beat shift register is reset too, so a
   // mid-job rst cannot leave stale enables flowing into the slice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         first_pend_q <= 1'b0;
         vld_q        <= '0;
         last_q       <= '0;
         first_q      <= '0;
         res_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         first_pend_q <= first_pend_d;
         vld_q        <= vld_d;
         last_q       <= last_d;
         first_q      <= first_d;
         res_data_q   <= res_data_d;
      end
   end

   assign busy_o         = (state_q != S_IDLE);
   assign in_ready_o     = (state_q == S_ACCUM);
   assign res_valid_o    = (state_q == S_DONE);
   assign res_data_o     = res_data_q;

   assign dsp_a_o        = in_a_i;
   assign dsp_b_o        = in_b_i;
   assign dsp_cea_o      = beat;
   assign dsp_ceb_o      = beat;
   assign dsp_cem_o      = vld_q[1];
   assign dsp_ceopmode_o = vld_q[FD];
   assign dsp_cep_o      = vld_q[MUL_LAT];
   // First beat loads P from M alone; later beats add M onto the held P.
   assign dsp_opmode_o   = vld_q[FD] ? (first_q[FD] ? OPM_FIRST : OPM_ACC) : OPM_IDLE;

`ifdef DSP_MAC_OVF_EN
   logic ovf_q, ovf_d;

   // Carry-out is meaningful only in the cycle right after one of this job's P updates.
   always_comb begin
      ovf_d = ovf_q;
      if (state_q == S_IDLE && start_i) begin
         ovf_d = 1'b0;
      end else if (vld_q[PD] && dsp_carryout_i) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign res_ovf_o = ovf_q;
`else
   logic unused_carryout;
   assign unused_carryout = dsp_carryout_i;
   assign res_ovf_o       = 1'b0;
`endif

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Controller that drives a DSP48A1 slice (the `DSP` module) as a multiply-accumulate engine. It accepts a job length and a valid/ready stream of (a, b) operand pairs, and generates the slice's per-cycle OPMODE and clock-enable strobes. It then returns the accumulated 48-bit sum through a valid/ready result port. It sits between a sample source and one `DSP` instance configured with A0REG=0, B0REG=0, A1REG=1, B1REG=1, MREG=1, OPMODEREG=1, PREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5".

## Interface
- LEN_W, 8, width of job length.
- MUL_LAT, 2, cycles from operands driven on dsp_a/dsp_b to product valid at post-adder input.
- OPMODE_LAT, 1, OPMODE register depth in the slice; must satisfy 1 ≤ OPMODE_LAT < MUL_LAT.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request, sampled only in IDLE.
- len  in  LEN_W  number of operand pairs, sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid / in_ready  in / out  1  operand handshake.
- in_a, in_b  in  18  unsigned operands.
- dsp_a, dsp_b  out  18  to slice A, B.
- dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep  out  1  slice clock enables.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_p  in  48  slice P.
- dsp_carryout  in  1  slice CARRYOUT.
- res_valid / res_ready  out / in  1  result handshake.
- res_data  out  48  accumulated sum.
- res_ovf  out  1  sticky carry-out flag.

## Operation
- States:
  - IDLE: `start & len!=0` loads the remaining count = len and moves to ACCUM. `start & len==0` moves to DONE with res_data=0 and generates no slice activity.
  - ACCUM: in_ready=1. A beat fires when in_valid & in_ready; the count decrements. On the beat where count==1, move to DRAIN.
  - DRAIN: in_ready=0. Wait until the last beat has cleared the pipeline.
  - DONE: res_valid=1; on res_ready, return to IDLE.
- dsp_a=in_a and dsp_b=in_b combinationally. dsp_cea=dsp_ceb=beat fire.
- Each beat pushes {valid, first} into a MUL_LAT-deep shift register. Bubbles push valid=0.
- dsp_cem = beat valid at delay 1.
- dsp_ceopmode = beat valid at delay MUL_LAT-OPMODE_LAT.
  - dsp_opmode = 8'h01 (Z=0, X=M) for the first beat.
  - dsp_opmode = 8'h09 (Z=P, X=M) for later beats.
  - dsp_opmode = 8'h00 when no beat is at that delay.
- dsp_cep = beat valid at delay MUL_LAT. P holds through bubbles.
- The cycle after the last beat's cep, capture dsp_p into res_data and enter DONE.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored.
- res_data and res_ovf hold stable while res_valid=1 and res_ready=0.

## Timing
- All outputs reset to 0 and the state resets to IDLE.
- A start accepted in cycle 0 gives in_ready=1 from cycle 1.
- For a last beat fired in cycle t:
  - dsp_cep is high in cycle t+MUL_LAT.
  - P is valid in cycle t+MUL_LAT+1, when it is captured.
  - res_valid is high from cycle t+MUL_LAT+2.
- For a len=0 start in cycle 0, res_valid is high from cycle 1.
- Throughput is one pair per cycle; there is no gap between consecutive beats.
- Back-to-back jobs: res handshake in cycle n returns to IDLE in cycle n+1, and start is accepted from cycle n+1.
- rst mid-job: immediate return to IDLE; all enables and outputs go to 0; the pipeline shift register clears. The partial sum is discarded.

## Configuration
- DSP_MAC_OVF_EN defined:
  - res_ovf clears at job start.
  - res_ovf sets if dsp_carryout=1 in any cycle following a dsp_cep cycle of the current job.
  - res_ovf is valid with res_valid.
- DSP_MAC_OVF_EN undefined: res_ovf is tied to 0 and the carry logic is absent.

## Test plan
- len=4, pairs (1,2),(3,4),(5,6),(7,8) with in_valid held high and a behavioural slice model. Required: res_data=100, and res_valid rises 4 cycles after the 4th beat fires.
- Same job with in_valid low for 2 cycles between beats 2 and 3. Required: dsp_cep is low for 2 matching cycles and res_data=100.
- len=0. Required: res_valid in the next cycle with res_data=0, and dsp_ce* stays 0 throughout.
- res_ready held low for 5 cycles, start pulsed during DONE. Required: res_data stays stable, start is ignored, and IDLE is reached one cycle after res_ready.
- rst asserted after 2 of 4 beats. Required: all outputs are 0 asynchronously. A new len=1 job with (3,3) then returns 9.
- With DSP_MAC_OVF_EN, len=2, model carryout=1 after beat 2. Required: res_ovf=1. The following clean job returns res_ovf=0.
